// File: rtl/buffer_pkg.sv
// Shared defaults for the circular Buffer and its buffer_reader controller.
// Both instantiations take their parameters from here so the write width,
// window width and depth always agree.
//   DEF_SIZE      : word width in bits
//   DEF_MEM_SIZE  : Buffer depth in words (any value, not only powers of 2)
//   DEF_PAR_WRITE : words written per commit
//   DEF_PAR_READ  : words per output window
//   DEF_STRIDE    : words retired per accepted window
package buffer_pkg;

    localparam int DEF_SIZE      = 16;
    localparam int DEF_MEM_SIZE  = 8;
    localparam int DEF_PAR_WRITE = 4;
    localparam int DEF_PAR_READ  = 2;
    localparam int DEF_STRIDE    = 1;

endpackage

// File: rtl/buffer.sv
// Circular parallel-write / parallel-read word store.
// A write places PAR_WRITE consecutive words starting at waddr, and a read
// returns PAR_READ consecutive words starting at raddr. Both wrap modulo
// MEM_SIZE. The read is combinational because buffer_reader registers the
// window itself. Word 0 sits in the LSBs on both data ports.
// Ports:
//   clk   : clock
//   wen   : write enable for all PAR_WRITE words
//   waddr : first write address
//   wdata : PAR_WRITE words, word 0 in the LSBs
//   raddr : first read address
//   dout  : PAR_READ words, word 0 in the LSBs
module buffer
    import buffer_pkg::*;
#(
    parameter int SIZE      = DEF_SIZE,
    parameter int MEM_SIZE  = DEF_MEM_SIZE,
    parameter int PAR_WRITE = DEF_PAR_WRITE,
    parameter int PAR_READ  = DEF_PAR_READ,
    parameter int ADDR_W    = $clog2(MEM_SIZE)
) (
    input  logic                      clk,
    input  logic                      wen,
    input  logic [ADDR_W-1:0]         waddr,
    input  logic [SIZE*PAR_WRITE-1:0] wdata,
    input  logic [ADDR_W-1:0]         raddr,
    output logic [SIZE*PAR_READ-1:0]  dout
);

    logic [SIZE-1:0]   mem    [MEM_SIZE];
    logic [ADDR_W-1:0] wr_idx [PAR_WRITE];
    logic [ADDR_W-1:0] rd_idx [PAR_READ];

    // Per-lane wrapped addresses; lane gi is the base address plus gi.
    generate
        for (genvar gi = 0; gi < PAR_WRITE; gi++) begin : g_wr_lane
            ptr_wrap_add #(
                .MEM_SIZE (MEM_SIZE),
                .INC      (gi),
                .ADDR_W   (ADDR_W)
            ) u_wr_add (
                .ptr_i  (waddr),
                .next_o (wr_idx[gi])
            );
        end

        for (genvar gi = 0; gi < PAR_READ; gi++) begin : g_rd_lane
            ptr_wrap_add #(
                .MEM_SIZE (MEM_SIZE),
                .INC      (gi),
                .ADDR_W   (ADDR_W)
            ) u_rd_add (
                .ptr_i  (raddr),
                .next_o (rd_idx[gi])
            );
            assign dout[gi*SIZE +: SIZE] = mem[rd_idx[gi]];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (wen) begin
            for (int i = 0; i < PAR_WRITE; i++) begin
                mem[wr_idx[i]] <= wdata[i*SIZE +: SIZE];
            end
        end
    end

endmodule

// File: rtl/ptr_wrap_add.sv
// Combinational modulo increment for a circular-buffer pointer:
//   next_o = (ptr_i + INC) mod MEM_SIZE
// The sum is formed one bit wider than the pointer and wrapped by a single
// conditional subtract. This is exact for any MEM_SIZE, including non-powers
// of 2, as long as ptr_i < MEM_SIZE and INC <= MEM_SIZE.
// Ports:
//   ptr_i  : current pointer, ADDR_W bits
//   next_o : incremented and wrapped pointer, ADDR_W bits
module ptr_wrap_add #(
    parameter int MEM_SIZE = 8,
    parameter int INC      = 1,
    parameter int ADDR_W   = $clog2(MEM_SIZE)
) (
    input  logic [ADDR_W-1:0] ptr_i,
    output logic [ADDR_W-1:0] next_o
);

    localparam logic [ADDR_W:0] INC_W = (ADDR_W+1)'(INC);
    localparam logic [ADDR_W:0] MEM_W = (ADDR_W+1)'(MEM_SIZE);

    logic [ADDR_W:0] sum;

    assign sum    = {1'b0, ptr_i} + INC_W;
    assign next_o = (sum >= MEM_W) ? ADDR_W'(sum - MEM_W) : ADDR_W'(sum);

endmodule

// File: rtl/buffer_reader.sv
// Pointer and read-side controller for the circular Buffer.
// It owns the write pointer, the read pointer and the occupancy count, and
// gives the writer a ready/commit handshake. It loads PAR_READ-word windows
// from the Buffer into a registered valid/ready output stage. Each accepted
// window retires STRIDE words, so consecutive windows overlap by
// PAR_READ-STRIDE words.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   wr_commit  : writer stores PAR_WRITE words at waddr this cycle
//   wr_ready   : at least PAR_WRITE free words (from registered count only)
//   waddr      : write pointer
//   raddr      : read pointer
//   buf_dout   : Buffer window at raddr (combinational)
//   flush      : synchronous clear of pointers, count and the output stage
//   out_valid  : out_data holds a window
//   out_ready  : consumer accepts the window
//   out_data   : window, oldest word in the LSBs
//   count      : unretired words in the Buffer
//   err        : sticky, set by a commit while wr_ready=0
module buffer_reader
    import buffer_pkg::*;
#(
    parameter int SIZE        = DEF_SIZE,
    parameter int MEM_SIZE    = DEF_MEM_SIZE,
    parameter int PAR_WRITE   = DEF_PAR_WRITE,
    parameter int PAR_READ    = DEF_PAR_READ,
    parameter int STRIDE      = DEF_STRIDE,
    parameter int ADDRES_SIZE = $clog2(MEM_SIZE),
    parameter int CNT_SIZE    = $clog2(MEM_SIZE+1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_commit,
    output logic                     wr_ready,
    output logic [ADDRES_SIZE-1:0]   waddr,
    output logic [ADDRES_SIZE-1:0]   raddr,
    input  logic [SIZE*PAR_READ-1:0] buf_dout,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [SIZE*PAR_READ-1:0] out_data,
    output logic [CNT_SIZE-1:0]      count,
    output logic                     err
);

    localparam logic [CNT_SIZE-1:0] WR_LIMIT = CNT_SIZE'(MEM_SIZE - PAR_WRITE);
    localparam logic [CNT_SIZE-1:0] RD_MIN   = CNT_SIZE'(PAR_READ);
    localparam logic [CNT_SIZE-1:0] PW_C     = CNT_SIZE'(PAR_WRITE);
    localparam logic [CNT_SIZE-1:0] ST_C     = CNT_SIZE'(STRIDE);

    logic [ADDRES_SIZE-1:0]   wptr_q, wptr_d, wptr_inc;
    logic [ADDRES_SIZE-1:0]   rptr_q, rptr_d, rptr_inc;
    logic [CNT_SIZE-1:0]      count_q, count_d;
    logic                     out_valid_q, out_valid_d;
    logic [SIZE*PAR_READ-1:0] out_data_q, out_data_d;
    logic                     err_q, err_d;

    logic commit_ok;
    logic load;

    ptr_wrap_add #(
        .MEM_SIZE (MEM_SIZE),
        .INC      (PAR_WRITE),
        .ADDR_W   (ADDRES_SIZE)
    ) u_wptr_add (
        .ptr_i  (wptr_q),
        .next_o (wptr_inc)
    );

    ptr_wrap_add #(
        .MEM_SIZE (MEM_SIZE),
        .INC      (STRIDE),
        .ADDR_W   (ADDRES_SIZE)
    ) u_rptr_add (
        .ptr_i  (rptr_q),
        .next_o (rptr_inc)
    );

    // count still includes the overlap words of the pending window, so
    // free space never covers words that the output stage may read again.
    assign wr_ready  = (count_q <= WR_LIMIT);
    assign commit_ok = wr_commit & wr_ready;
    assign load      = (~out_valid_q | out_ready) & (count_q >= RD_MIN);

    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        err_d       = err_q;

        if (flush) begin
            // err deliberately survives a flush.
            wptr_d      = '0;
            rptr_d      = '0;
            count_d     = '0;
            out_valid_d = 1'b0;
            out_data_d  = '0;
        end else begin
            if (commit_ok) begin
                wptr_d = wptr_inc;
            end
            if (wr_commit & ~wr_ready) begin
                err_d = 1'b1;
            end

            if (load) begin
                out_data_d  = buf_dout;
                out_valid_d = 1'b1;
                rptr_d      = rptr_inc;
            end else if (out_valid_q & out_ready) begin
                // The last window was taken and nothing is ready to follow.
                // out_data keeps its old value.
                out_valid_d = 1'b0;
            end

            // A commit is accepted only when count <= MEM_SIZE-PAR_WRITE, and
            // a load requires count >= STRIDE. So neither the intermediate nor
            // the final value overflows or underflows.
            count_d = count_q + (commit_ok ? PW_C : '0) - (load ? ST_C : '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            err_q       <= err_d;
        end
    end

    assign waddr     = wptr_q;
    assign raddr     = rptr_q;
    assign count     = count_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign err       = err_q;

endmodule

// File: tb/tb_buffer_reader.sv
// Bench for buffer_reader connected to a real Buffer instance.
// The reference model treats the Buffer contents as a queue of unretired
// words: a window is the first PAR_READ entries of the queue, and an
// accepted window pops STRIDE entries.
module tb_buffer_reader;
    import buffer_pkg::*;

    localparam int SIZE = DEF_SIZE;
    localparam int MEM  = DEF_MEM_SIZE;
    localparam int PW   = DEF_PAR_WRITE;
    localparam int PR   = DEF_PAR_READ;
    localparam int ST   = DEF_STRIDE;
    localparam int AW   = $clog2(MEM);
    localparam int CW   = $clog2(MEM+1);

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 wr_commit = 1'b0;
    logic                 wr_ready;
    logic [AW-1:0]        waddr, raddr;
    logic [SIZE*PR-1:0]   buf_dout;
    logic                 flush = 1'b0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [SIZE*PR-1:0]   out_data;
    logic [CW-1:0]        count;
    logic                 err;
    logic [SIZE*PW-1:0]   wdata = '0;
    logic                 buf_wen;

    // The Buffer write is gated with wr_ready so that rejected commits
    // cannot corrupt unretired words.
    assign buf_wen = wr_commit & wr_ready;

    always #5 clk = ~clk;

    buffer #(
        .SIZE(SIZE), .MEM_SIZE(MEM), .PAR_WRITE(PW), .PAR_READ(PR), .ADDR_W(AW)
    ) u_buf (
        .clk(clk), .wen(buf_wen), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .dout(buf_dout)
    );

    buffer_reader #(
        .SIZE(SIZE), .MEM_SIZE(MEM), .PAR_WRITE(PW), .PAR_READ(PR), .STRIDE(ST)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wr_commit(wr_commit), .wr_ready(wr_ready),
        .waddr(waddr), .raddr(raddr), .buf_dout(buf_dout), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count), .err(err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [SIZE-1:0]    q[$];
    int                 m_wptr = 0;
    int                 m_rptr = 0;
    bit                 m_ov   = 1'b0;
    bit                 m_err  = 1'b0;
    logic [SIZE*PR-1:0] m_od   = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("%s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".count"},     64'(count),     64'(q.size()));
        chk({tag, ".wr_ready"},  64'(wr_ready),  64'((MEM - q.size()) >= PW));
        chk({tag, ".waddr"},     64'(waddr),     64'(m_wptr));
        chk({tag, ".raddr"},     64'(raddr),     64'(m_rptr));
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(m_ov));
        chk({tag, ".out_data"},  64'(out_data),  64'(m_od));
        chk({tag, ".err"},       64'(err),       64'(m_err));
    endtask

    task automatic model_clear(input bit keep_err);
        q.delete();
        m_wptr = 0;
        m_rptr = 0;
        m_ov   = 1'b0;
        m_od   = '0;
        if (!keep_err) m_err = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs applied for it.
    task automatic model_step(input bit c, input logic [SIZE*PW-1:0] w,
                              input bit r, input bit f);
        bit ok, ld;
        if (f) begin
            model_clear(1'b1);
        end else begin
            ok = c && ((MEM - q.size()) >= PW);
            ld = (!m_ov || r) && (q.size() >= PR);
            if (ld) begin
                for (int i = 0; i < PR; i++) m_od[i*SIZE +: SIZE] = q[i];
                for (int i = 0; i < ST; i++) void'(q.pop_front());
                m_rptr = (m_rptr + ST) % MEM;
                m_ov   = 1'b1;
            end else if (m_ov && r) begin
                m_ov = 1'b0;
            end
            if (ok) begin
                for (int i = 0; i < PW; i++) q.push_back(w[i*SIZE +: SIZE]);
                m_wptr = (m_wptr + PW) % MEM;
            end
            if (c && !ok) m_err = 1'b1;
        end
    endtask

    // One clock: apply inputs, step the model, sample #1 after the edge.
    task automatic cycle(input string tag, input bit c, input logic [SIZE*PW-1:0] w,
                         input bit r, input bit f);
        wr_commit = c;
        wdata     = w;
        out_ready = r;
        flush     = f;
        model_step(c, w, r, f);
        @(posedge clk);
        #1;
        $display("[%0t] %s commit=%0b ready=%0b flush=%0b -> count=%0d valid=%0b data=%h raddr=%0d waddr=%0d err=%0b",
                 $time, tag, c, r, f, count, out_valid, out_data, raddr, waddr, err);
        check_all(tag);
        wr_commit = 1'b0;
        flush     = 1'b0;
    endtask

    // PAR_WRITE consecutive words base, base+1, ...
    function automatic logic [SIZE*PW-1:0] seq(input int base);
        logic [SIZE*PW-1:0] v;
        for (int i = 0; i < PW; i++) v[i*SIZE +: SIZE] = SIZE'(base + i);
        return v;
    endfunction

    // Expected window whose oldest word is 'first' (consecutive words).
    function automatic logic [SIZE*PR-1:0] win(input int first);
        logic [SIZE*PR-1:0] v;
        for (int i = 0; i < PR; i++) v[i*SIZE +: SIZE] = SIZE'(first + i);
        return v;
    endfunction

    initial begin
        // 1. Reset held for 3 cycles
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_clear(1'b0);
        check_all("reset");
        chk("reset.wr_ready_hi", 64'(wr_ready), 64'd1);

        // 2. Single commit of words 1..4, consumer always ready
        cycle("t2.commit", 1'b1, seq(1), 1'b1, 1'b0);
        chk("t2.count4", 64'(count), 64'd4);
        cycle("t2.win0", 1'b0, '0, 1'b1, 1'b0);
        chk("t2.win0.data", 64'(out_data), 64'(win(1)));
        cycle("t2.win1", 1'b0, '0, 1'b1, 1'b0);
        chk("t2.win1.data", 64'(out_data), 64'(win(2)));
        cycle("t2.win2", 1'b0, '0, 1'b1, 1'b0);
        chk("t2.win2.data", 64'(out_data), 64'(win(3)));
        cycle("t2.drop", 1'b0, '0, 1'b1, 1'b0);
        chk("t2.drop.valid", 64'(out_valid), 64'd0);
        chk("t2.drop.count", 64'(count), 64'd1);
        chk("t2.drop.raddr", 64'(raddr), 64'd3);

        // 3. Fill: two commits with consumer stalled, then a rejected third
        cycle("t3.flush", 1'b0, '0, 1'b0, 1'b1);
        cycle("t3.commit1", 1'b1, seq(16'h21), 1'b0, 1'b0);
        cycle("t3.commit2", 1'b1, seq(16'h25), 1'b0, 1'b0);
        chk("t3.count7", 64'(count), 64'd7);
        chk("t3.wr_ready_lo", 64'(wr_ready), 64'd0);
        cycle("t3.reject", 1'b1, seq(16'h90), 1'b0, 1'b0);
        chk("t3.reject.waddr", 64'(waddr), 64'd0);
        chk("t3.reject.count", 64'(count), 64'd7);
        chk("t3.reject.err", 64'(err), 64'd1);

        // 4. Backpressure for 5 cycles, then release
        for (int i = 0; i < 5; i++) begin
            cycle("t4.stall", 1'b0, '0, 1'b0, 1'b0);
            chk("t4.stall.data", 64'(out_data), 64'(win(16'h21)));
            chk("t4.stall.raddr", 64'(raddr), 64'd1);
            chk("t4.stall.count", 64'(count), 64'd7);
        end
        cycle("t4.release", 1'b0, '0, 1'b1, 1'b0);
        chk("t4.release.data", 64'(out_data), 64'(win(16'h22)));
        for (int i = 0; i < 5; i++) cycle("t4.drain", 1'b0, '0, 1'b1, 1'b0);
        chk("t4.drain.raddr", 64'(raddr), 64'd7);

        // 5. Wrap-around: new words land at 0..3 while the read pointer sits at 7
        cycle("t5.commit", 1'b1, seq(10), 1'b0, 1'b0);
        chk("t5.waddr", 64'(waddr), 64'd4);
        cycle("t5.wrapwin", 1'b0, '0, 1'b1, 1'b0);
        chk("t5.wrapwin.data", 64'(out_data), 64'h0000_0000_000A_0028);
        chk("t5.wrapwin.raddr", 64'(raddr), 64'd0);
        cycle("t5.fill", 1'b1, seq(16'h30), 1'b0, 1'b0);
        chk("t5.full.count", 64'(count), 64'(MEM));
        chk("t5.full.wr_ready", 64'(wr_ready), 64'd0);
        for (int i = 0; i < 3; i++) cycle("t5.consume", 1'b0, '0, 1'b1, 1'b0);

        // 6. Flush mid-stream at count=5 with a window pending
        chk("t6.pre.count", 64'(count), 64'd5);
        cycle("t6.flush", 1'b0, '0, 1'b0, 1'b1);
        chk("t6.count", 64'(count), 64'd0);
        chk("t6.valid", 64'(out_valid), 64'd0);
        chk("t6.err_held", 64'(err), 64'd1);

        // Asynchronous reset mid-stream clears state without a clock edge
        cycle("t7.commit", 1'b1, seq(16'h40), 1'b0, 1'b0);
        cycle("t7.load", 1'b0, '0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("t7.async.valid", 64'(out_valid), 64'd0);
        chk("t7.async.count", 64'(count), 64'd0);
        chk("t7.async.err", 64'(err), 64'd0);
        model_clear(1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_all("t7.release");

        // Randomized traffic against the queue model
        for (int i = 0; i < 500; i++) begin
            cycle("rand", ($urandom_range(0, 1) == 1), SIZE*PW'({$urandom, $urandom}),
                  ($urandom_range(0, 9) < 7), ($urandom_range(0, 49) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
